// File: rtl/pythag_leg_solver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pythag_leg_solver_pkg
// Description : Shared definitions for the Pythagorean leg solver: FSM state
//               encoding, default operand width and iteration counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pythag_leg_solver_pkg;

    // Default operand width (r, x, y); squares and differences use 2x this.
    localparam int WIDTH_DEF  = 8;

    // Width of the root iteration counter for the default operand width.
    localparam int ITER_CNT_W = $clog2(WIDTH_DEF);

    // Controller states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_ROOT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Counter width for an arbitrary operand width; never narrower than 1 bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage : pythag_leg_solver_pkg
`default_nettype wire

// File: rtl/pythag_leg_solver_isqrt_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_iter_step
// Description : One combinational step of a bitwise integer square root.
//               The remainder tracks (radicand - root^2). Trying bit 'pos'
//               raises root^2 by (root << (pos+1)) + (1 << 2*pos); the bit
//               is kept when that increase still fits in the remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_iter_step #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic [2*WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0]   root_i,
    input  logic [CNT_W-1:0]   pos_i,
    output logic [2*WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0]   root_o
);

    // One extra bit so the trial increase never wraps for the top bit.
    localparam int                DW       = 2 * WIDTH + 1;
    localparam logic [DW-1:0]     ONE_DW   = DW'(1);
    localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);

    logic [CNT_W:0]   shift_lin;
    logic [CNT_W:0]   shift_sq;
    logic [DW-1:0]    root_ext;
    logic [DW-1:0]    delta;
    logic [DW-1:0]    rem_ext;
    logic             keep;

    // Trial increase of root^2 for this bit, compare, and conditionally commit.
    always_comb begin
        shift_lin = {1'b0, pos_i} + 1'b1;
        shift_sq  = {pos_i, 1'b0};
        root_ext  = {{(WIDTH + 1){1'b0}}, root_i};
        delta     = (root_ext << shift_lin) + (ONE_DW << shift_sq);
        rem_ext   = {1'b0, rem_i};
        keep      = (rem_ext >= delta);
        rem_o     = keep ? (rem_i - delta[2*WIDTH-1:0]) : rem_i;
        root_o    = keep ? (root_i | (ONE_W << pos_i)) : root_i;
    end

endmodule : isqrt_iter_step
`default_nettype wire

// File: rtl/pythag_leg_solver.sv
`default_nettype none
// ============================================================================
// Module      : pythag_leg_solver
// Description : Computes y = floor(sqrt(r*r - x*x)) over WIDTH+1 enabled
//               cycles (one cycle for the difference of squares, WIDTH cycles
//               of bitwise root), with start/busy/done handshake. x > r is
//               reported through err after a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pythag_leg_solver
    import pythag_leg_solver_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] x_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y_out,
    output logic             err
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    state_e               state_q;
    state_e               state_d;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     x_q;
    logic [2*WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]     res_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     y_q;
    logic                 err_q;

    logic [2*WIDTH-1:0]   r_sq;
    logic [2*WIDTH-1:0]   x_sq;
    logic [2*WIDTH-1:0]   diff_d;
    logic                 x_gt_r;
    logic [2*WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]     res_d;

    // Difference of squares; only consumed when x <= r, so it cannot underflow.
    always_comb begin
        r_sq   = {{WIDTH{1'b0}}, r_q} * {{WIDTH{1'b0}}, r_q};
        x_sq   = {{WIDTH{1'b0}}, x_q} * {{WIDTH{1'b0}}, x_q};
        x_gt_r = (x_q > r_q);
        diff_d = r_sq - x_sq;
    end

    isqrt_iter_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .rem_i  (rem_q),
        .root_i (res_q),
        .pos_i  (cnt_q),
        .rem_o  (rem_d),
        .root_o (res_d)
    );

    // State register; ena=0 freezes the controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CALC;
            ST_CALC: state_d = x_gt_r ? ST_DONE : ST_ROOT;
            ST_ROOT: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_CALC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, root iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            x_q   <= '0;
            rem_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
        end else if (ena) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_q   <= r_in;
                        x_q   <= x_in;
                        err_q <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (x_gt_r) begin
                        err_q <= 1'b1;
                        y_q   <= '0;
                    end else begin
                        rem_q <= diff_d;
                        res_q <= '0;
                        cnt_q <= CNT_INIT;
                    end
                end
                ST_ROOT: begin
                    rem_q <= rem_d;
                    res_q <= res_d;
                    if (cnt_q == '0) begin
                        y_q   <= res_d;
                        err_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decoded from state; results come straight from registers.
    always_comb begin
        busy  = (state_q == ST_CALC) || (state_q == ST_ROOT);
        done  = (state_q == ST_DONE);
        y_out = y_q;
        err   = err_q;
    end

endmodule : pythag_leg_solver
`default_nettype wire

// File: tb/tb_pythag_leg_solver.sv
`default_nettype none
// ============================================================================
// Module      : tb_pythag_leg_solver
// Description : Self-checking bench for pythag_leg_solver. A cycle-level
//               reference model predicts busy/done/y/err from the request
//               stream; a compare process checks every cycle, and directed
//               cases pin latencies and results with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pythag_leg_solver;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [W-1:0] r_in;
    logic [W-1:0] x_in;
    logic         busy;
    logic         done;
    logic [W-1:0] y_out;
    logic         err;

    int n_cmp;
    int n_bad;

    // Reference model state
    logic m_busy, m_done, m_err, p_err;
    int   m_y, p_y, m_left;
    int   rv, xv;

    pythag_leg_solver #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .r_in  (r_in),
        .x_in  (x_in),
        .busy  (busy),
        .done  (done),
        .y_out (y_out),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int isqrt_ref(input int d);
        int y;
        y = 0;
        while ((y + 1) * (y + 1) <= d) y++;
        return y;
    endfunction

    // Model: a request occupies WIDTH+1 enabled cycles (1 on x > r), then done for one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_y = 0; m_left = 0;
            p_err = 1'b0; p_y = 0;
        end else if (ena) begin
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_y = p_y; m_err = p_err;
                end
            end else begin
                m_done = 1'b0;
                if (start) begin
                    rv = int'(r_in);
                    xv = int'(x_in);
                    m_busy = 1'b1;
                    m_err  = 1'b0;
                    if (xv > rv) begin
                        p_err = 1'b1; p_y = 0; m_left = 1;
                    end else begin
                        p_err = 1'b0; p_y = isqrt_ref(rv * rv - xv * xv); m_left = W + 1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("err", int'(err), int'(m_err));
            chk("y_out", int'(y_out), m_y);
        end
    end

    // Issue one request at the current negedge and wait (bounded) for done.
    task automatic issue(input int r, input int x, output int lat);
        start = 1'b1;
        r_in  = W'(r);
        x_in  = W'(x);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_req(input int r, input int x, input int ey, input int ee, input int el);
        int lat;
        issue(r, x, lat);
        chk("latency", lat, el);
        chk("y_lit", int'(y_out), ey);
        chk("err_lit", int'(err), ee);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        r_in  = '0;
        x_in  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, issued back-to-back in the DONE cycle
        run_req(5, 3, 4, 0, 9);
        run_req(10, 7, 7, 0, 9);
        run_req(255, 0, 255, 0, 9);
        run_req(10, 10, 0, 0, 9);
        run_req(3, 5, 0, 1, 1);
        run_req(13, 5, 12, 0, 9);
        run_req(0, 0, 0, 0, 9);
        run_req(200, 100, 173, 0, 9);

        // Enable stall during ROOT plus an ignored start while busy
        start = 1'b1; r_in = 8'd10; x_in = 8'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (3) begin @(negedge clk); lat++; end
        ena = 1'b0;
        repeat (4) begin @(negedge clk); lat++; end
        chk("frozen_y", int'(y_out), 173);
        chk("frozen_busy", int'(busy), 1);
        ena = 1'b1;
        start = 1'b1; r_in = 8'd200; x_in = 8'd0;
        @(negedge clk); lat++;
        start = 1'b0;
        while (!done && lat < 60) begin @(negedge clk); lat++; end
        chk("stall_latency", lat, 13);
        chk("stall_y", int'(y_out), 7);
        ena = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_held", int'(done), 1);
        ena = 1'b1;
        @(negedge clk);
        chk("done_cleared", int'(done), 0);

        // Asynchronous reset mid-ROOT
        start = 1'b1; r_in = 8'd200; x_in = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_y", int'(y_out), 0);
        chk("arst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req(25, 24, 7, 0, 9);

        // Strided sweep plus the x = r diagonal, back-to-back
        for (int r = 0; r < 256; r++) begin
            for (int x = 0; x < 256; x += 17) issue(r, x, lat);
            issue(r, r, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pythag_leg_solver
`default_nettype wire
